score_display_ctrl: RTL and testbench
=====================================

Name: score_display_ctrl

Overview:
- Game-level controller that sequences the collision score display.
- Counts collision events from the car/obstacle detector, with a post-hit cooldown window, and runs the IDLE/PLAYING/GAME_OVER state machine.
- Drives the 6-bit collision value and display-enable inputs of the two-digit 7-segment score decoder, and blinks the display at game over.
- Sits between the game logic (collision detector, start key) and the HEX decoder.

Parameters:
- MAX_COLLISIONS, 9: count value that ends the game. Legal range is 1..63.
- COOLDOWN, 50_000_000: cycles after a counted hit during which further hits are ignored. 0 disables the cooldown.
- BLINK_DIV, 25_000_000: cycles per blink half-period in GAME_OVER. Must be ≥1.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  synchronous start/restart level, sampled each cycle.
- CollisionIn  in  1  synchronous collision level from the detector. May stay high for many cycles.
- collision  out  6  current collision count, to the decoder.
- DisplayEnable  out  1  decoder blank control; 1 = show digits.
- Playing  out  1  high in PLAYING (and PAUSED when built).
- GameOver  out  1  high in GAME_OVER.

Behaviour:
- Reset (Resetn=0, asynchronous) forces:
  - state = IDLE; collision = 0; DisplayEnable = 0; Playing = 0; GameOver = 0.
  - cooldown counter = 0, blink counter = 0, blink phase = 1, CollisionIn history register = 0.
  - Reset mid-game aborts immediately; there is no partial state.
- Edge detect: a hit is CollisionIn=1 while the registered previous CollisionIn=0. A held-high level counts once only.
- IDLE:
  - collision = 0, DisplayEnable = 0.
  - Start=1 → PLAYING on the next edge; collision stays 0 and the cooldown counter is cleared.
- PLAYING:
  - A hit with cooldown = 0 is counted:
    - collision increments on that clock edge, so it is visible 1 cycle after the edge sample.
    - The cooldown counter loads COOLDOWN and then decrements by 1 per cycle down to 0.
  - Hits seen while cooldown ≠ 0 are ignored, but the edge history still updates.
  - When the counted hit makes collision == MAX_COLLISIONS, the state moves to GAME_OVER on the same edge.
    - Blink counter is set to 0 and blink phase to 1.
  - collision saturates: it never exceeds MAX_COLLISIONS and never wraps.
  - Start is ignored in PLAYING.
  - DisplayEnable = 1, Playing = 1.
- GAME_OVER:
  - collision is frozen; GameOver = 1.
  - The blink counter counts 0..BLINK_DIV-1. On wrap, blink phase toggles.
  - DisplayEnable = blink phase, so the display is on for the first BLINK_DIV cycles after entry.
  - Hits are ignored.
  - Start=1 → PLAYING with collision = 0 and cooldown = 0. A hit in the same cycle is not counted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCORE_PAUSE_EN.
- When defined:
  - Adds input port Pause (1 bit, synchronous level) after CollisionIn.
  - Adds state PAUSED. In PLAYING, Pause=1 → PAUSED; in PAUSED, Pause=0 → PLAYING.
  - In PAUSED the cooldown counter freezes and hits are ignored, but edge history still updates, so a level held across resume is not counted.
  - In PAUSED: DisplayEnable = 1, Playing = 1.
  - Pause is ignored in IDLE and GAME_OVER.
  - If Pause=1 and a countable hit occur together in PLAYING, the hit is counted and the state still moves to PAUSED (or to GAME_OVER if the count reaches the limit; GAME_OVER has priority).
- When undefined: no Pause port and no PAUSED state.

Test Plan:
Bench parameters for all scenarios: MAX_COLLISIONS=3, COOLDOWN=3, BLINK_DIV=4.
1. Reset, then Start=1 for 1 cycle → Playing=1, DisplayEnable=1, collision=0. Resetn pulsed low mid-game → all outputs 0 immediately, without waiting for a clock edge.
2. Hold CollisionIn high for 10 cycles → collision=1 only, 1 cycle after the first high sample.
3. Hit, then a second hit 2 cycles later (inside cooldown) → collision stays 1. A third hit ≥4 cycles after the first → collision=2.
4. Three spaced hits → collision=3, GameOver=1, Playing=0. DisplayEnable pattern is 1×4, 0×4, 1×4. Further hits leave collision=3.
5. In GAME_OVER, assert Start and CollisionIn in the same cycle → PLAYING, collision=0 (hit not counted).
6. With SCORE_PAUSE_EN: Pause=1 for 5 cycles with CollisionIn toggling → collision unchanged, DisplayEnable=1. After Pause=0, a new rising edge → count +1.

Source files
------------

// File: rtl/score_display_ctrl.sv
// Collision score sequencer driving the two-digit HEX score decoder.
// Optional pause support is compiled in with `define SCORE_PAUSE_EN.
module score_display_ctrl #(
  parameter int MAX_COLLISIONS = 9,
  parameter int COOLDOWN       = 50_000_000,
  parameter int BLINK_DIV      = 25_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic       CollisionIn,
`ifdef SCORE_PAUSE_EN
  input  logic       Pause,
`endif
  output logic [5:0] collision,
  output logic       DisplayEnable,
  output logic       Playing,
  output logic       GameOver
);

  // state       | meaning
  // S_IDLE      | waiting for Start, display blanked, score cleared
  // S_PLAYING   | counting hits with post-hit cooldown
  // S_GAME_OVER | score frozen at limit, display blinking
  // S_PAUSED    | hits and cooldown frozen (pause build only)
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAYING   = 2'd1,
    S_GAME_OVER = 2'd2,
    S_PAUSED    = 2'd3
  } state_t;

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [5:0]      MAX_CNT = 6'(MAX_COLLISIONS);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  state_t          state, state_nxt;
  logic            collin_q;
  logic [CD_W-1:0] cd_cnt;
  logic [BL_W-1:0] blink_cnt, blink_cnt_nxt;
  logic            blink_ph, blink_ph_nxt;
  logic            hit, count_hit, reach_max, restart, pause_req;
  logic            de_nxt, play_nxt, go_nxt;

`ifdef SCORE_PAUSE_EN
  assign pause_req = Pause;
`else
  assign pause_req = 1'b0;
`endif

  assign hit       = CollisionIn & ~collin_q;
  assign count_hit = (state == S_PLAYING) && hit && (cd_cnt == '0) && (collision < MAX_CNT);
  assign reach_max = count_hit && ((collision + 6'd1) == MAX_CNT);
  assign restart   = (state == S_GAME_OVER) && Start;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Game-over on the limiting hit wins over a simultaneous pause request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (Start) state_nxt = S_PLAYING;
      S_PLAYING: begin
        if (reach_max)      state_nxt = S_GAME_OVER;
        else if (pause_req) state_nxt = S_PAUSED;
      end
      S_PAUSED:    if (!pause_req) state_nxt = S_PLAYING;
      S_GAME_OVER: if (Start) state_nxt = S_PLAYING;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_nxt = '0;
    blink_ph_nxt  = 1'b1;
    if ((state == S_GAME_OVER) && (state_nxt == S_GAME_OVER)) begin
      if (blink_cnt == BL_LAST) begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = ~blink_ph;
      end else begin
        blink_cnt_nxt = blink_cnt + BL_W'(1);
        blink_ph_nxt  = blink_ph;
      end
    end
  end

  always_comb begin
    de_nxt   = 1'b0;
    play_nxt = 1'b0;
    go_nxt   = 1'b0;
    case (state_nxt)
      S_PLAYING, S_PAUSED: begin
        de_nxt   = 1'b1;
        play_nxt = 1'b1;
      end
      S_GAME_OVER: begin
        de_nxt = blink_ph_nxt;
        go_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      collin_q      <= 1'b0;
      collision     <= '0;
      cd_cnt        <= '0;
      blink_cnt     <= '0;
      blink_ph      <= 1'b1;
      DisplayEnable <= 1'b0;
      Playing       <= 1'b0;
      GameOver      <= 1'b0;
    end else begin
      collin_q      <= CollisionIn;
      blink_cnt     <= blink_cnt_nxt;
      blink_ph      <= blink_ph_nxt;
      DisplayEnable <= de_nxt;
      Playing       <= play_nxt;
      GameOver      <= go_nxt;

      if ((state == S_IDLE) || restart) collision <= '0;
      else if (count_hit)               collision <= collision + 6'd1;

      // Cooldown only runs while actively playing; it holds in pause and game over.
      if ((state == S_IDLE) || restart)               cd_cnt <= '0;
      else if (count_hit)                             cd_cnt <= CD_LOAD;
      else if ((state == S_PLAYING) && (cd_cnt != '0)) cd_cnt <= cd_cnt - CD_W'(1);
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with MAX_COLLISIONS=3, COOLDOWN=3, BLINK_DIV=4.
module tb_score_display_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic       CollisionIn;
`ifdef SCORE_PAUSE_EN
  logic       Pause;
`endif
  logic [5:0] collision;
  logic       DisplayEnable;
  logic       Playing;
  logic       GameOver;

  int compared   = 0;
  int mismatched = 0;

  score_display_ctrl #(
    .MAX_COLLISIONS(3),
    .COOLDOWN      (3),
    .BLINK_DIV     (4)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Start        (Start),
    .CollisionIn  (CollisionIn),
`ifdef SCORE_PAUSE_EN
    .Pause        (Pause),
`endif
    .collision    (collision),
    .DisplayEnable(DisplayEnable),
    .Playing      (Playing),
    .GameOver     (GameOver)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_game();
    CollisionIn = 1'b0;
    Start       = 1'b0;
    Resetn      = 1'b0;
    #2;
    Resetn = 1'b1;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic pulse_hit(input int gap);
    CollisionIn = 1'b1;
    tick();
    CollisionIn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    #3;
    compared++;
    if ({collision, DisplayEnable, Playing, GameOver} !== 9'd0) begin
      $display("FAIL reset_outputs: got %0h expected 0", {collision, DisplayEnable, Playing, GameOver});
      mismatched++;
    end
    Resetn = 1'b1;
    tick();
    tick();
    compared++;
    if ({collision, DisplayEnable, Playing, GameOver} !== 9'd0) begin
      $display("FAIL idle_outputs: got %0h expected 0", {collision, DisplayEnable, Playing, GameOver});
      mismatched++;
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    compared++;
    if (Playing !== 1'b1 || DisplayEnable !== 1'b1 || collision !== 6'd0 || GameOver !== 1'b0) begin
      $display("FAIL start_playing: got P=%0d DE=%0d C=%0d GO=%0d expected 1 1 0 0",
               Playing, DisplayEnable, collision, GameOver);
      mismatched++;
    end
    pulse_hit(1);
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL pre_abort_count: got %0d expected 1", collision);
      mismatched++;
    end
    #2;
    Resetn = 1'b0;
    #1;
    compared++;
    if ({collision, DisplayEnable, Playing, GameOver} !== 9'd0) begin
      $display("FAIL async_abort: got %0h expected 0", {collision, DisplayEnable, Playing, GameOver});
      mismatched++;
    end
    Resetn = 1'b1;
  endtask

  task automatic test_held_level();
    start_game();
    CollisionIn = 1'b1;
    tick();
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL held_first: got %0d expected 1", collision);
      mismatched++;
    end
    repeat (9) tick();
    CollisionIn = 1'b0;
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL held_once: got %0d expected 1", collision);
      mismatched++;
    end
  endtask

  task automatic test_cooldown();
    start_game();
    pulse_hit(1);
    pulse_hit(0);
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL cooldown_ignore: got %0d expected 1", collision);
      mismatched++;
    end
    CollisionIn = 1'b0;
    tick();
    pulse_hit(0);
    compared++;
    if (collision !== 6'd2) begin
      $display("FAIL cooldown_expired: got %0d expected 2", collision);
      mismatched++;
    end
  endtask

  task automatic test_cooldown_boundary();
    start_game();
    pulse_hit(2);
    pulse_hit(0);
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL cooldown_last_cycle: got %0d expected 1", collision);
      mismatched++;
    end
    CollisionIn = 1'b0;
    tick();
    pulse_hit(0);
    compared++;
    if (collision !== 6'd2) begin
      $display("FAIL cooldown_after_boundary: got %0d expected 2", collision);
      mismatched++;
    end
  endtask

  task automatic test_game_over();
    logic exp_de;
    start_game();
    pulse_hit(4);
    pulse_hit(4);
    pulse_hit(0);
    compared++;
    if (collision !== 6'd3 || GameOver !== 1'b1 || Playing !== 1'b0) begin
      $display("FAIL game_over_entry: got C=%0d GO=%0d P=%0d expected 3 1 0",
               collision, GameOver, Playing);
      mismatched++;
    end
    for (int i = 0; i < 12; i++) begin
      exp_de = (i < 4) || (i >= 8);
      compared++;
      if (DisplayEnable !== exp_de) begin
        $display("FAIL blink_%0d: got %0d expected %0d", i, DisplayEnable, exp_de);
        mismatched++;
      end
      tick();
    end
    pulse_hit(1);
    pulse_hit(1);
    compared++;
    if (collision !== 6'd3 || GameOver !== 1'b1) begin
      $display("FAIL game_over_frozen: got C=%0d GO=%0d expected 3 1", collision, GameOver);
      mismatched++;
    end
  endtask

  task automatic test_restart();
    Start       = 1'b1;
    CollisionIn = 1'b1;
    tick();
    Start = 1'b0;
    compared++;
    if (Playing !== 1'b1 || GameOver !== 1'b0 || collision !== 6'd0 || DisplayEnable !== 1'b1) begin
      $display("FAIL restart: got P=%0d GO=%0d C=%0d DE=%0d expected 1 0 0 1",
               Playing, GameOver, collision, DisplayEnable);
      mismatched++;
    end
    tick();
    CollisionIn = 1'b0;
    compared++;
    if (collision !== 6'd0) begin
      $display("FAIL restart_held: got %0d expected 0", collision);
      mismatched++;
    end
    tick();
    pulse_hit(0);
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL restart_cooldown_clear: got %0d expected 1", collision);
      mismatched++;
    end
  endtask

`ifdef SCORE_PAUSE_EN
  task automatic test_pause();
    start_game();
    Pause = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      CollisionIn = ~i[0];
      tick();
      compared++;
      if (collision !== 6'd0 || DisplayEnable !== 1'b1 || Playing !== 1'b1) begin
        $display("FAIL paused_%0d: got C=%0d DE=%0d P=%0d expected 0 1 1",
                 i, collision, DisplayEnable, Playing);
        mismatched++;
      end
    end
    Pause = 1'b0;
    tick();
    compared++;
    if (collision !== 6'd0) begin
      $display("FAIL resume_held: got %0d expected 0", collision);
      mismatched++;
    end
    CollisionIn = 1'b0;
    tick();
    pulse_hit(0);
    compared++;
    if (collision !== 6'd1) begin
      $display("FAIL resume_hit: got %0d expected 1", collision);
      mismatched++;
    end
  endtask
`endif

  initial begin
    Resetn      = 1'b0;
    Start       = 1'b0;
    CollisionIn = 1'b0;
`ifdef SCORE_PAUSE_EN
    Pause       = 1'b0;
`endif
    test_reset();
    test_held_level();
    test_cooldown();
    test_cooldown_boundary();
    test_game_over();
    test_restart();
`ifdef SCORE_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
